// File: rtl/cam_index_decoder.sv
// Decodes a stream of CAM entry indices into an OR-accumulated entry-select
// vector per frame, with a distinct-entry count and a duplicate flag.

module cam_idx_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_sel,
  output logic o_bit,
  output logic o_nxt
);
  logic r_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_bit <= 1'b0;
    else if (i_clr) r_bit <= 1'b0;
    else if (i_sel) r_bit <= 1'b1;
  end

  assign o_bit = r_bit;
  assign o_nxt = r_bit | i_sel;
endmodule

module cam_index_decoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             idx_valid_i,
  output logic             idx_ready_o,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             idx_last_i,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic [WIDTH-1:0] vec_o,
  output logic [IDX_W:0]   vec_cnt_o,
  output logic             vec_dup_o
);
  typedef enum logic {S_EMPTY, S_ACCUM} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] w_acc, w_acc_nxt, w_sel;
  logic [IDX_W:0]   r_acc_cnt, w_cnt_nxt;
  logic             r_acc_dup, w_dup_nxt;
  logic             w_accept, w_fire_last, w_acc_clr, w_hit;
  logic [WIDTH-1:0] r_vec;
  logic [IDX_W:0]   r_vec_cnt;
  logic             r_vec_dup, r_vec_valid;

  // Ready depends only on the slot state, never on the beat itself.
  assign idx_ready_o = !r_vec_valid || vec_ready_i;
  assign w_accept    = idx_valid_i && idx_ready_o;
  assign w_fire_last = w_accept && idx_last_i && !clear_i;
  assign w_acc_clr   = clear_i || w_fire_last;
  assign w_sel       = w_accept ? ({{(WIDTH-1){1'b0}}, 1'b1} << idx_i) : '0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    cam_idx_cell u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_clr  (w_acc_clr),
      .i_sel  (w_sel[g]),
      .o_bit  (w_acc[g]),
      .o_nxt  (w_acc_nxt[g])
    );
  end

  assign w_hit     = |(w_acc & w_sel);
  assign w_cnt_nxt = r_acc_cnt + {{IDX_W{1'b0}}, (w_accept && !w_hit)};
  assign w_dup_nxt = r_acc_dup | w_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (!clear_i && w_accept && !idx_last_i) w_state_nxt = S_ACCUM;
      S_ACCUM: if (clear_i || (w_accept && idx_last_i)) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_cnt <= '0;
      r_acc_dup <= 1'b0;
    end else if (w_acc_clr) begin
      r_acc_cnt <= '0;
      r_acc_dup <= 1'b0;
    end else if (w_accept) begin
      r_acc_cnt <= w_cnt_nxt;
      r_acc_dup <= w_dup_nxt;
    end
  end

  // Result slot: a reload wins over the handshake so back-to-back frames have no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vec       <= '0;
      r_vec_cnt   <= '0;
      r_vec_dup   <= 1'b0;
      r_vec_valid <= 1'b0;
    end else if (w_fire_last) begin
      r_vec       <= w_acc_nxt;
      r_vec_cnt   <= w_cnt_nxt;
      r_vec_dup   <= w_dup_nxt;
      r_vec_valid <= 1'b1;
    end else if (vec_ready_i) begin
      r_vec_valid <= 1'b0;
    end
  end

  assign vec_valid_o = r_vec_valid;
  assign vec_o       = r_vec;
  assign vec_cnt_o   = r_vec_cnt;
  assign vec_dup_o   = r_vec_dup;
endmodule
